// File: rtl/io_cond_pkg.sv
// io_cond_pkg: shared definitions for the io_conditioner block.
//   DATA_W            register bus data width
//   REG_DATA..REG_LED word addresses of the 4-entry register map
//   edge_mode_e       which debounced transitions latch an EDGE bit
package io_cond_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_LED  = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

endpackage

// File: rtl/io_debounce_ch.sv
// io_debounce_ch: one input channel -- 2-FF synchroniser followed by a
// counter-based debouncer and the accepted (stable) level flop.
//   Clk    system clock
//   Reset  asynchronous, active-high reset
//   din    polarity-normalised raw pin level (asynchronous)
//   level  debounced level; follows din only after it has held a new
//          value for DEBOUNCE_CYCLES consecutive synchronised samples
module io_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      // Any sample equal to the accepted level restarts the count.
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_conditioner.sv
// io_conditioner: conditions N_IN board inputs (polarity, sync, debounce,
// edge capture with masked interrupt) and drives N_LED LEDs, all behind a
// 4-word register bus (DATA RO, EDGE W1C, MASK RW, LED RW).
//   Clk, Reset     system clock, asynchronous active-high reset
//   raw_in         asynchronous board inputs
//   addr/read/write/writedata  register bus; readdata registered on read
//   irq            high while any unmasked EDGE bit is set (registered)
//   led_out        LED drive, active-high
// Optional build macro IO_COND_LED_BLINK_EN: LED word bits [31:16] hold a
// per-LED BLINK mask gated by a free-running 24-bit prescaler phase.
module io_conditioner
  import io_cond_pkg::*;
#(
  parameter int unsigned N_IN            = 10,
  parameter int unsigned N_LED           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] ACTIVE_LOW_MASK = 32'b11,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_IN-1:0]   raw_in,
  input  logic [1:0]        addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic [N_LED-1:0]  led_out
);

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

  logic [N_IN-1:0]   norm;
  logic [N_IN-1:0]   st;
  logic [N_IN-1:0]   st_d;
  logic [N_IN-1:0]   edge_q;
  logic [N_IN-1:0]   edge_set;
  logic [N_IN-1:0]   edge_clr;
  logic [N_IN-1:0]   mask_q;
  logic [N_LED-1:0]  led_q;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wd;

  assign unused_wd = ^writedata;

  assign norm = raw_in ^ ACTIVE_LOW_MASK[N_IN-1:0];

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    io_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .Clk  (Clk),
      .Reset(Reset),
      .din  (norm[i]),
      .level(st[i])
    );
  end

  always_comb begin
    edge_set = '0;
    if (MODE == EDGE_RISE)      edge_set = st & ~st_d;
    else if (MODE == EDGE_FALL) edge_set = ~st & st_d;
    else                        edge_set = st ^ st_d;
  end

  assign edge_clr = (write && addr == REG_EDGE) ? writedata[N_IN-1:0] : '0;

`ifdef IO_COND_LED_BLINK_EN
  localparam int unsigned BLINK_W = (N_LED < 16) ? N_LED : 16;

  logic [BLINK_W-1:0] blink_q;
  logic [23:0]        presc;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_q <= '0;
      presc   <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (write && addr == REG_LED) blink_q <= writedata[16 +: BLINK_W];
    end
  end

  // Blinking LEDs are forced dark during the low half of the phase.
  always_comb begin
    led_out = led_q;
    for (int unsigned i = 0; i < BLINK_W; i++) begin
      if (blink_q[i] && !presc[23]) led_out[i] = 1'b0;
    end
  end
`else
  assign led_out = led_q;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_DATA: rd_mux[N_IN-1:0] = st;
      REG_EDGE: rd_mux[N_IN-1:0] = edge_q;
      REG_MASK: rd_mux[N_IN-1:0] = mask_q;
      REG_LED: begin
        rd_mux[N_LED-1:0] = led_q;
`ifdef IO_COND_LED_BLINK_EN
        rd_mux[16 +: BLINK_W] = blink_q;
`endif
      end
      default: rd_mux = '0;
    endcase
  end

  // The mux samples pre-write register values, so a read coinciding with a
  // write returns the old contents.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st_d     <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      led_q    <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      st_d   <= st;
      // A new edge wins over a simultaneous write-1-clear of the same bit.
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      if (write && addr == REG_MASK) mask_q <= writedata[N_IN-1:0];
      if (write && addr == REG_LED)  led_q  <= writedata[N_LED-1:0];
      irq <= |(edge_q & mask_q);
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_io_conditioner.sv
// tb_io_conditioner: directed scenarios plus randomized traffic for
// io_conditioner (N_IN=10, N_LED=8, DEBOUNCE_CYCLES=4, rising edges),
// checked every cycle against a behavioural model of the register view.
module tb_io_conditioner;

  localparam int N  = 10;
  localparam int NL = 8;
  localparam int DC = 4;
  localparam int EM = 0;
  localparam logic [9:0] ALM = 10'b0000000011;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  raw_in = ALM;
  logic [1:0]  addr = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  led_out;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  io_conditioner #(
    .N_IN(N),
    .N_LED(NL),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW_MASK(32'b11),
    .EDGE_MODE(EM)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .raw_in(raw_in),
    .addr(addr),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .led_out(led_out)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a channel's accepted level flips once the last DC
  // synchronised samples (pin value from two clocks earlier) all disagree
  // with it. EDGE/MASK/LED/irq/readdata follow the register rules.
  bit [9:0]  m_p0, m_p1, m_st, m_st_prev, m_edge, m_mask;
  bit [9:0]  m_hist [DC];
  bit [7:0]  m_led;
  bit        m_irq;
  bit [31:0] m_rd;
  bit [7:0]  m_blink;
  bit [23:0] m_pre;

  always @(posedge Clk or posedge Reset) begin : model
    bit [9:0]  s, nst, set;
    bit        all_new;
    if (Reset) begin
      m_p0 = '0; m_p1 = '0; m_st = '0; m_st_prev = '0;
      m_edge = '0; m_mask = '0; m_led = '0; m_irq = 1'b0; m_rd = '0;
      m_blink = '0; m_pre = '0;
      for (int k = 0; k < DC; k++) m_hist[k] = '0;
    end else begin
      s = m_p1;
      for (int k = DC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = s;
      nst = m_st;
      for (int c = 0; c < N; c++) begin
        all_new = 1'b1;
        for (int k = 0; k < DC; k++) if (m_hist[k][c] == m_st[c]) all_new = 1'b0;
        if (all_new) nst[c] = ~m_st[c];
      end
      case (EM)
        0:       set = m_st & ~m_st_prev;
        1:       set = ~m_st & m_st_prev;
        default: set = m_st ^ m_st_prev;
      endcase
      if (read) begin
        case (addr)
          2'd0: m_rd = {22'd0, m_st};
          2'd1: m_rd = {22'd0, m_edge};
          2'd2: m_rd = {22'd0, m_mask};
          default: begin
            m_rd = {24'd0, m_led};
`ifdef IO_COND_LED_BLINK_EN
            m_rd[23:16] = m_blink;
`endif
          end
        endcase
      end
      m_irq = |(m_edge & m_mask);
      if (write && addr == 2'd1) m_edge = (m_edge & ~writedata[9:0]) | set;
      else                       m_edge = m_edge | set;
      if (write && addr == 2'd2) m_mask = writedata[9:0];
      if (write && addr == 2'd3) begin
        m_led = writedata[7:0];
        m_blink = writedata[23:16];
      end
      m_pre = m_pre + 1;
      m_st_prev = m_st;
      m_st = nst;
      m_p1 = m_p0;
      m_p0 = raw_in ^ ALM;
    end
  end

  function automatic logic [7:0] exp_led();
`ifdef IO_COND_LED_BLINK_EN
    return m_led & (~m_blink | {8{m_pre[23]}});
`else
    return m_led;
`endif
  endfunction

  always @(negedge Clk) begin
    if (chk_en) begin
      check("mon_irq", {31'd0, irq}, {31'd0, m_irq});
      check("mon_led", {24'd0, led_out}, {24'd0, exp_led()});
      check("mon_rdata", readdata, m_rd);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; writedata = d; write = 1'b1;
    @(negedge Clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a; read = 1'b1;
    @(negedge Clk);
    read = 1'b0;
    d = readdata;
  endtask

  // Reads DATA every cycle and returns how many cycles pass until bit ch
  // appears in readdata (st latency plus one register-read cycle).
  task automatic wait_data(input int ch, input int start, output int n);
    n = start;
    addr = 2'd0; read = 1'b1;
    while (n < 30) begin
      @(negedge Clk);
      n++;
      if (readdata[ch]) break;
    end
    read = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int n, r;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk_en = 1'b1;

    // Reset state with keys idle high.
    rd(2'd0, d); check("rst_data", d, 32'h0);
    rd(2'd1, d); check("rst_edge", d, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_led", {24'd0, led_out}, 32'h0);

    // KEY0 pressed: st after 2+DC clocks, visible in readdata one later.
    raw_in[0] = 1'b0;
    wait_data(0, 0, n);
    check("lat_ch0", n, 7);
    rd(2'd1, d); check("edge_ch0", d, 32'h1);
    check("irq_masked", {31'd0, irq}, 32'h0);

    // Glitch train on SW0 (ch2): 2-cycle pulses never reach DC samples.
    addr = 2'd0; read = 1'b1;
    for (int j = 0; j < 10; j++) begin
      raw_in[2] = ~raw_in[2];
      repeat (2) begin
        @(negedge Clk);
        check("glitch_data", {31'd0, readdata[2]}, 32'h0);
      end
    end
    read = 1'b0;
    raw_in[2] = 1'b1;
    repeat (10) @(negedge Clk);
    rd(2'd1, d); check("edge_glitch", d, 32'h5);

    // Masked interrupt, W1C racing a new edge, then a clean clear.
    wr(2'd1, 32'h5);
    wr(2'd2, 32'h4);
    raw_in[2] = 1'b0; repeat (10) @(negedge Clk);
    raw_in[2] = 1'b1;
    repeat (7) @(negedge Clk);
    check("irq_pre", {31'd0, irq}, 32'h0);
    @(negedge Clk);
    check("irq_set", {31'd0, irq}, 32'h1);
    raw_in[2] = 1'b0; repeat (10) @(negedge Clk);
    raw_in[2] = 1'b1;
    repeat (6) @(negedge Clk);
    wr(2'd1, 32'h4);
    check("irq_race", {31'd0, irq}, 32'h1);
    rd(2'd1, d); check("edge_race", d, 32'h4);
    check("irq_hold", {31'd0, irq}, 32'h1);
    wr(2'd1, 32'h4);
    @(negedge Clk);
    check("irq_clr", {31'd0, irq}, 32'h0);

    // LED register and read-only DATA.
    wr(2'd3, 32'hA5);
    check("led_a5", {24'd0, led_out}, 32'hA5);
    rd(2'd3, d); check("rd_led", d, 32'hA5);
    wr(2'd0, 32'hFFFF);
    rd(2'd0, d); check("data_ro", d, 32'h5);

    // Reset while SW1 (ch3) is mid-count.
    raw_in[3] = 1'b1;
    repeat (4) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("arst_led", {24'd0, led_out}, 32'h0);
    check("arst_rdata", readdata, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    addr = 2'd1; read = 1'b1;
    @(negedge Clk);
    check("arst_edge", readdata, 32'h0);
    wait_data(3, 1, n);
    check("lat_after_rst", n, 7);

    // Randomized traffic, one asynchronous reset pulse in the middle.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        #3 Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, N - 1);
        raw_in[r] = ~raw_in[r];
      end
      r = $urandom_range(0, 9);
      addr = 2'($urandom_range(0, 3));
      writedata = $urandom;
      read  = (r < 4) || (r == 9);
      write = (r >= 6);
      @(negedge Clk);
      read = 1'b0; write = 1'b0;
    end

    for (int a = 0; a < 4; a++) rd(2'(a), d);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
